// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared definitions for the memory arbiter controller.
//   state_t   : FSM state encoding (IDLE, ACCESS, DONE)
//   RW_READ   : direction value for a read request
//   RW_WRITE  : direction value for a write request
//   CNT_W     : width of the access wait counter (covers WAIT up to 15)
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin selector. Searches the request vector
// starting at the pointer position and wrapping around.
// Ports:
//   req   : per-channel request bits
//   ptr   : channel index with highest priority this cycle
//   grant : one-hot grant (all zero when nothing requests)
//   idx   : encoded index of the granted channel
module rr_arbiter #(
  parameter int NCH  = 2,
  parameter int IDXW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [IDXW-1:0] ptr,
  output logic [NCH-1:0]  grant,
  output logic [IDXW-1:0] idx
);

  logic [2*NCH-1:0] doubled;
  logic [NCH-1:0]   rotated;
  logic [IDXW:0]    sum;
  logic             found;

  // Rotate the requests so the pointer channel lands at bit 0, take the
  // first set bit, then map it back to an absolute channel index modulo NCH.
  always_comb begin
    doubled = {req, req};
    rotated = NCH'(doubled >> ptr);
    sum     = '0;
    found   = 1'b0;
    idx     = '0;
    grant   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!found && rotated[i]) begin
        found = 1'b1;
        sum   = (IDXW+1)'(i) + {1'b0, ptr};
        if (sum >= (IDXW+1)'(NCH)) begin
          sum = sum - (IDXW+1)'(NCH);
        end
        idx = sum[IDXW-1:0];
      end
    end
    if (found) begin
      grant = {{(NCH-1){1'b0}}, 1'b1} << idx;
    end
  end

endmodule

// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl
// Arbitrates NCH requester channels onto a single memory port. One
// transaction at a time: grant in IDLE, hold the memory enable for WAIT
// cycles in ACCESS, pulse done to the served channel in DONE.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   valid, rw         : per-channel request strobe and direction (1 = write)
//   addr_in, wdata    : per-channel packed address / write data
//   done              : one-cycle one-hot completion pulse
//   rdata             : read data, updated only on read completion
//   busy              : high whenever not in IDLE
//   Addr, mem_wdata   : memory address and write data (latched per grant)
//   mem_rdata         : memory read data
//   rdEn, wrEn        : memory read / write enables
module mem_arb_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ADWIDTH = 16,
  parameter int NCH     = 2,
  parameter int WAIT    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         valid,
  input  logic [NCH-1:0]         rw,
  input  logic [NCH*ADWIDTH-1:0] addr_in,
  input  logic [NCH*WIDTH-1:0]   wdata,
  output logic [NCH-1:0]         done,
  output logic [WIDTH-1:0]       rdata,
  output logic                   busy,
  output logic [ADWIDTH-1:0]     Addr,
  output logic [WIDTH-1:0]       mem_wdata,
  input  logic [WIDTH-1:0]       mem_rdata,
  output logic                   rdEn,
  output logic                   wrEn
);

  localparam int IDXW = $clog2(NCH);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT - 1);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [IDXW-1:0]    ptr;
  logic [NCH-1:0]     gnt;
  logic [IDXW-1:0]    gnt_idx;
  logic [NCH-1:0]     gnt_q;
  logic               rw_q;
  logic [ADWIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]   sel_wdata;
  logic               sel_rw;

  rr_arbiter #(
    .NCH  (NCH),
    .IDXW (IDXW)
  ) u_arb (
    .req   (valid),
    .ptr   (ptr),
    .grant (gnt),
    .idx   (gnt_idx)
  );

  // Pick out the granted channel's address, data and direction.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_rw    = RW_READ;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_idx == IDXW'(i)) begin
        sel_addr  = addr_in[i*ADWIDTH +: ADWIDTH];
        sel_wdata = wdata[i*WIDTH +: WIDTH];
        sel_rw    = rw[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode. Enables are a pure function of the state
  // and latched direction, so a reset drops them on the very next cycle.
  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    rdEn       = 1'b0;
    wrEn       = 1'b0;
    done       = '0;
    case (state)
      IDLE: begin
        if (|valid) begin
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        rdEn = (rw_q == RW_READ);
        wrEn = (rw_q == RW_WRITE);
        if (cnt == '0) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done       = gnt_q;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Transaction datapath: latch the request on grant, count down the access,
  // capture read data on the final access cycle. The pointer moves to the
  // channel after the one just granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      ptr       <= '0;
      gnt_q     <= '0;
      rw_q      <= RW_READ;
      Addr      <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|valid) begin
            cnt       <= WAIT_LOAD;
            gnt_q     <= gnt;
            rw_q      <= sel_rw;
            Addr      <= sel_addr;
            mem_wdata <= sel_wdata;
            ptr       <= (gnt_idx == IDXW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (rw_q == RW_READ) begin
              rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// tb_mem_arb_ctrl
// Directed bench for mem_arb_ctrl. Instance a: NCH=2, WAIT=2 (single read,
// single write, dropped valid, reset mid-access, two-channel contention).
// Instance b: NCH=4, WAIT=1 (four-channel rotation).
module tb_mem_arb_ctrl;

  logic        clk = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // Instance a signals
  logic        reset_a;
  logic [1:0]  valid_a;
  logic [1:0]  rw_a;
  logic [31:0] addr_in_a;
  logic [63:0] wdata_a;
  logic [1:0]  done_a;
  logic [31:0] rdata_a;
  logic        busy_a;
  logic [15:0] addr_a;
  logic [31:0] mem_wdata_a;
  logic [31:0] mem_rdata_a;
  logic        rd_en_a;
  logic        wr_en_a;

  // Instance b signals
  logic         reset_b;
  logic [3:0]   valid_b;
  logic [3:0]   rw_b;
  logic [63:0]  addr_in_b;
  logic [127:0] wdata_b;
  logic [3:0]   done_b;
  logic [31:0]  rdata_b;
  logic         busy_b;
  logic [15:0]  addr_b;
  logic [31:0]  mem_wdata_b;
  logic [31:0]  mem_rdata_b;
  logic         rd_en_b;
  logic         wr_en_b;

  mem_arb_ctrl #(.WIDTH(32), .ADWIDTH(16), .NCH(2), .WAIT(2)) dut_a (
    .clk       (clk),
    .reset     (reset_a),
    .valid     (valid_a),
    .rw        (rw_a),
    .addr_in   (addr_in_a),
    .wdata     (wdata_a),
    .done      (done_a),
    .rdata     (rdata_a),
    .busy      (busy_a),
    .Addr      (addr_a),
    .mem_wdata (mem_wdata_a),
    .mem_rdata (mem_rdata_a),
    .rdEn      (rd_en_a),
    .wrEn      (wr_en_a)
  );

  mem_arb_ctrl #(.WIDTH(32), .ADWIDTH(16), .NCH(4), .WAIT(1)) dut_b (
    .clk       (clk),
    .reset     (reset_b),
    .valid     (valid_b),
    .rw        (rw_b),
    .addr_in   (addr_in_b),
    .wdata     (wdata_b),
    .done      (done_b),
    .rdata     (rdata_b),
    .busy      (busy_b),
    .Addr      (addr_b),
    .mem_wdata (mem_wdata_b),
    .mem_rdata (mem_rdata_b),
    .rdEn      (rd_en_b),
    .wrEn      (wr_en_b)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one request pattern onto instance a.
  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] dir,
                               input logic [15:0] a0, input logic [15:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1);
    valid_a   = v;
    rw_a      = dir;
    addr_in_a = {a1, a0};
    wdata_a   = {d1, d0};
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [1:0]  exp_done_a;
    logic [15:0] exp_addr_a;
    logic [3:0]  exp_done_b;
    int          k;

    reset_a     = 1'b1;
    reset_b     = 1'b1;
    mem_rdata_a = 32'h0;
    mem_rdata_b = 32'h5555AAAA;
    applyStimulus(2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0);
    valid_b     = 4'b0000;
    rw_b        = 4'b0000;
    addr_in_b   = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    wdata_b     = '0;

    // Reset state
    stepCycle();
    stepCycle();
    checkOutput("rst_busy",  64'(busy_a),      64'h0);
    checkOutput("rst_done",  64'(done_a),      64'h0);
    checkOutput("rst_rdata", 64'(rdata_a),     64'h0);
    checkOutput("rst_addr",  64'(addr_a),      64'h0);
    checkOutput("rst_wdata", 64'(mem_wdata_a), 64'h0);
    checkOutput("rst_en",    64'({rd_en_a, wr_en_a}), 64'h0);
    reset_a = 1'b0;
    stepCycle();
    checkOutput("idle_busy", 64'(busy_a), 64'h0);

    // Single read on ch0
    $display("[TB] single read");
    applyStimulus(2'b01, 2'b00, 16'h0010, 16'h0, 32'h0, 32'h0);
    mem_rdata_a = 32'hDEADBEEF;
    stepCycle();
    checkOutput("rd_c1_en",   64'({rd_en_a, wr_en_a}), 64'h2);
    checkOutput("rd_c1_addr", 64'(addr_a), 64'h0010);
    checkOutput("rd_c1_busy", 64'(busy_a), 64'h1);
    checkOutput("rd_c1_done", 64'(done_a), 64'h0);
    stepCycle();
    checkOutput("rd_c2_en",   64'({rd_en_a, wr_en_a}), 64'h2);
    stepCycle();
    checkOutput("rd_done",    64'(done_a), 64'h1);
    checkOutput("rd_done_en", 64'({rd_en_a, wr_en_a}), 64'h0);
    checkOutput("rd_rdata",   64'(rdata_a), 64'hDEADBEEF);
    applyStimulus(2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0);
    mem_rdata_a = 32'h0;
    stepCycle();
    checkOutput("rd_post_done", 64'(done_a), 64'h0);
    checkOutput("rd_post_busy", 64'(busy_a), 64'h0);
    checkOutput("rd_hold",      64'(rdata_a), 64'hDEADBEEF);

    // Single write on ch1
    $display("[TB] single write");
    applyStimulus(2'b10, 2'b10, 16'h0, 16'h00FF, 32'h0, 32'h12345678);
    stepCycle();
    checkOutput("wr_c1_en",    64'({rd_en_a, wr_en_a}), 64'h1);
    checkOutput("wr_c1_wdata", 64'(mem_wdata_a), 64'h12345678);
    checkOutput("wr_c1_addr",  64'(addr_a), 64'h00FF);
    stepCycle();
    checkOutput("wr_c2_en",    64'({rd_en_a, wr_en_a}), 64'h1);
    stepCycle();
    checkOutput("wr_done",     64'(done_a), 64'h2);
    checkOutput("wr_rdata",    64'(rdata_a), 64'hDEADBEEF);
    applyStimulus(2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0);
    stepCycle();

    // Valid dropped during ACCESS (pointer is back at ch0)
    $display("[TB] dropped valid");
    applyStimulus(2'b01, 2'b00, 16'h0020, 16'h0, 32'h0, 32'h0);
    mem_rdata_a = 32'hCAFEF00D;
    stepCycle();
    applyStimulus(2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0);
    checkOutput("drop_c1_addr", 64'(addr_a), 64'h0020);
    stepCycle();
    checkOutput("drop_c2_en", 64'({rd_en_a, wr_en_a}), 64'h2);
    stepCycle();
    checkOutput("drop_done",  64'(done_a), 64'h1);
    checkOutput("drop_rdata", 64'(rdata_a), 64'hCAFEF00D);
    stepCycle();

    // Reset in the first ACCESS cycle of a ch1 write
    $display("[TB] reset mid-access");
    applyStimulus(2'b10, 2'b10, 16'h0, 16'h0055, 32'h0, 32'hA5A5A5A5);
    stepCycle();
    checkOutput("abort_c1_en", 64'({rd_en_a, wr_en_a}), 64'h1);
    reset_a = 1'b1;
    stepCycle();
    checkOutput("abort_en",    64'({rd_en_a, wr_en_a}), 64'h0);
    checkOutput("abort_busy",  64'(busy_a), 64'h0);
    checkOutput("abort_done",  64'(done_a), 64'h0);
    checkOutput("abort_rdata", 64'(rdata_a), 64'h0);

    // Contention from reset release: grant order 0,1,0,1, one transaction
    // every 4 cycles, done in the fourth cycle of each.
    $display("[TB] contention");
    reset_a = 1'b0;
    applyStimulus(2'b11, 2'b00, 16'h0030, 16'h0040, 32'h0, 32'h0);
    for (int t = 1; t <= 16; t++) begin
      stepCycle();
      k          = (t - 1) / 4;
      exp_addr_a = (k % 2 == 0) ? 16'h0030 : 16'h0040;
      exp_done_a = 2'b00;
      if (t % 4 == 3) begin
        exp_done_a = (k % 2 == 0) ? 2'b01 : 2'b10;
      end
      checkOutput($sformatf("cont_done_t%0d", t), 64'(done_a), 64'(exp_done_a));
      if (t % 4 == 1 || t % 4 == 2) begin
        checkOutput($sformatf("cont_addr_t%0d", t), 64'(addr_a), 64'(exp_addr_a));
        checkOutput($sformatf("cont_rden_t%0d", t), 64'(rd_en_a), 64'h1);
      end
    end
    applyStimulus(2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0);

    // Four channels, WAIT=1: a transaction every 3 cycles, order 0,1,2,3,0.
    $display("[TB] four-channel rotation");
    reset_b = 1'b0;
    valid_b = 4'b1111;
    for (int t = 1; t <= 15; t++) begin
      stepCycle();
      exp_done_b = 4'b0000;
      if (t % 3 == 2) begin
        exp_done_b = 4'b0001 << ((t / 3) % 4);
      end
      checkOutput($sformatf("b_done_t%0d", t), 64'(done_b), 64'(exp_done_b));
      checkOutput($sformatf("b_rden_t%0d", t), 64'(rd_en_b), (t % 3 == 1) ? 64'h1 : 64'h0);
      if (t % 3 == 1) begin
        checkOutput($sformatf("b_addr_t%0d", t), 64'(addr_b), 64'(((t / 3) % 4) + 1));
      end
    end
    valid_b = 4'b0000;
    stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arb_ctrl.md
MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits.
REQ-002 Parameter ADWIDTH, default 16: address width in bits.
REQ-003 Parameter NCH, default 2: number of requester channels; legal range 2..8.
REQ-004 Parameter WAIT, default 2: memory access cycles per transaction; legal range 1..15.
REQ-005 Port clk, in, 1: single clock; all logic on its rising edge.
REQ-006 Port reset, in, 1: synchronous reset, active-high.
REQ-007 Port valid, in, NCH: per-channel request strobe.
REQ-008 Port rw, in, NCH: per-channel direction; 1 = write, 0 = read.
REQ-009 Port addr_in, in, NCH*ADWIDTH: per-channel address; channel i occupies bits [i*ADWIDTH +: ADWIDTH].
REQ-010 Port wdata, in, NCH*WIDTH: per-channel write data, packed as for addr_in.
REQ-011 Port done, out, NCH: one-cycle completion pulse, one-hot to the served channel.
REQ-012 Port rdata, out, WIDTH: read data, valid when done pulses for a read.
REQ-013 Port busy, out, 1: high whenever the FSM is not in IDLE.
REQ-014 Port Addr, out, ADWIDTH: memory address.
REQ-015 Port mem_wdata, out, WIDTH: memory write data.
REQ-016 Port mem_rdata, in, WIDTH: memory read data.
REQ-017 Ports rdEn and wrEn, out, 1 each: memory read and write enables.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-019 IDLE, any valid high: grant one channel round-robin, starting at the channel after the last granted; latch its addr, wdata, rw and index; load the wait counter with WAIT-1; go to ACCESS.
REQ-020 IDLE, no valid high: stay in IDLE; all memory enables low.
REQ-021 ACCESS: Addr and mem_wdata SHALL be held at the latched values; rdEn (read) or wrEn (write) SHALL be high for exactly WAIT consecutive cycles; never both high.
REQ-022 ACCESS, counter = 0: capture mem_rdata into rdata if the transaction is a read; go to DONE. Otherwise decrement the counter.
REQ-023 DONE: done[granted] high for exactly one cycle; rdEn and wrEn low; return to IDLE.
REQ-024 Latency: done SHALL assert WAIT+1 cycles after the IDLE cycle that granted the request. Peak throughput is one transaction per WAIT+2 cycles.
REQ-025 The requester SHALL keep valid high until it samples done. A valid still high in the IDLE cycle after DONE counts as a new request.
REQ-026 valid, rw, addr_in and wdata SHALL be ignored outside IDLE. A valid dropped mid-transaction SHALL NOT abort the transaction.
REQ-027 rdata SHALL hold its value across writes and idle cycles; it updates only on read completion.
REQ-028 With all channels requesting continuously, each channel SHALL be served once per NCH transactions; no channel starves.

Reset
REQ-029 While reset is high at a clock edge: FSM to IDLE, wait counter to 0, round-robin pointer to 0 (channel 0 highest priority on the next grant), and all outputs low (done, rdata, busy, Addr, mem_wdata, rdEn, wrEn).
REQ-030 Reset during ACCESS or DONE SHALL abort the transaction: no done pulse, and enables low from the next cycle.

Structure
REQ-031 Package mem_ctrl_pkg SHALL hold the state encoding (IDLE=2'b00, ACCESS=2'b01, DONE=2'b10) and the direction constants RW_READ=0 and RW_WRITE=1.
REQ-032 Sub-module rr_arbiter SHALL take NCH requests plus the pointer and return a one-hot grant and an encoded index; it is purely combinational. The pointer register lives in mem_arb_ctrl.

Verification
REQ-033 Single read: NCH=2, WAIT=2, ch0 read addr 0x0010, mem returns 0xDEADBEEF -> rdEn high for 2 cycles with Addr=0x0010; done=2'b01 on cycle 3; rdata=0xDEADBEEF.
REQ-034 Single write: ch1 write addr 0x00FF, data 0x12345678 -> wrEn high for 2 cycles with mem_wdata=0x12345678; done=2'b10; rdata unchanged.
REQ-035 Contention: both channels valid from reset release -> grant order ch0, ch1, ch0, ch1; each done is one-hot and one cycle long.
REQ-036 Reset mid-ACCESS (cycle 1 of 2) -> next cycle rdEn=0, wrEn=0, busy=0, no done pulse; the following request is granted to ch0.
REQ-037 WAIT=1, NCH=4, all channels valid -> transactions every 3 cycles, grant order 0,1,2,3,0.
REQ-038 valid dropped during ACCESS -> transaction still completes and done pulses.
